// File: rtl/wave_pkg.sv
// Shared constants for the wave_voice oscillator and the per-voice register file.
// Holds the waveform-select bit positions, the noise LFSR seed/taps and the silence code helper.
package wave_pkg;

    localparam int WSEL_SAWTOOTH = 0;
    localparam int WSEL_TRIANGLE = 1;
    localparam int WSEL_PULSE    = 2;
    localparam int WSEL_NOISE    = 3;
    localparam int WSEL_COUNT    = 4;

    // Seed is all ones with this many low zero bits; taps are offsets down from the top.
    localparam int LFSR_SEED_ZERO_BITS = 3;
    localparam int LFSR_TAP_HI         = 1;
    localparam int LFSR_TAP_LO         = 6;

    function automatic logic [31:0] midscale(input int bits);
        return 32'd1 << (bits - 1);
    endfunction

endpackage

// File: rtl/wave_lfsr.sv
// Noise LFSR: shifts left with feedback from two top taps when advanced, held at seed by reseed.
// State updates one cycle after advance_i/reseed_i; no backpressure.
module wave_lfsr #(
    parameter int LFSR_BITS = 23,
    parameter int OUT_BITS  = 12
) (
    input  logic                main_clk,
    input  logic                reset,
    input  logic                reseed_i,
    input  logic                advance_i,
    output logic [OUT_BITS-1:0] noise_o
);
    import wave_pkg::*;

    localparam logic [LFSR_BITS-1:0] SEED =
        {{(LFSR_BITS - LFSR_SEED_ZERO_BITS){1'b1}}, {LFSR_SEED_ZERO_BITS{1'b0}}};

    logic [LFSR_BITS-1:0] lfsr_q;
    logic [LFSR_BITS-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (reseed_i) begin
            lfsr_d = SEED;
        end else if (advance_i) begin
            lfsr_d = {lfsr_q[LFSR_BITS-2:0],
                      lfsr_q[LFSR_BITS-LFSR_TAP_HI] ^ lfsr_q[LFSR_BITS-LFSR_TAP_LO]};
        end
    end

    always_ff @(posedge main_clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign noise_o = lfsr_q[LFSR_BITS-1 -: OUT_BITS];

endmodule

// File: rtl/wave_voice.sv
// Oscillator voice: phase accumulator feeding AND-combined saw/triangle/pulse/noise, with sync and ring mod.
// Sample register updates one cycle after sample_en; free-running, no backpressure.
module wave_voice #(
    parameter int FREQ_BITS        = 16,
    parameter int PULSEWIDTH_BITS  = 12,
    parameter int OUTPUT_BITS      = 12,
    parameter int ACCUMULATOR_BITS = 24,
    parameter int NOISE_TAP_BIT    = 19,
    parameter int LFSR_BITS        = 23
) (
    input  logic                          main_clk,
    input  logic                          reset,
    input  logic [FREQ_BITS-1:0]          tone_freq,
    input  logic [PULSEWIDTH_BITS-1:0]    pulse_width,
    input  logic                          sample_en,
    input  logic                          test,
    input  logic                          en_sawtooth,
    input  logic                          en_triangle,
    input  logic                          en_pulse,
    input  logic                          en_noise,
    input  logic                          en_sync,
    input  logic                          sync_source,
    input  logic                          en_ringmod,
    input  logic                          ringmod_source,
    output logic signed [OUTPUT_BITS-1:0] out,
    output logic                          out_valid,
    output logic                          accumulator_msb,
    output logic                          sync_trigger_out
);
    import wave_pkg::*;

    localparam int MSB = ACCUMULATOR_BITS - 1;
    localparam logic [OUTPUT_BITS-1:0] MIDSCALE = OUTPUT_BITS'(midscale(OUTPUT_BITS));

    logic [MSB:0]             acc_q;
    logic [MSB:0]             acc_d;
    logic                     prev_msb_q;
    logic                     prev_tap_q;
    logic [OUTPUT_BITS-1:0]   out_q;
    logic                     out_valid_q;

    logic [WSEL_COUNT-1:0]    wsel;
    logic [OUTPUT_BITS-1:0]   saw_wave;
    logic [OUTPUT_BITS-1:0]   tri_base;
    logic [OUTPUT_BITS-1:0]   tri_wave;
    logic [OUTPUT_BITS-1:0]   pulse_wave;
    logic [OUTPUT_BITS-1:0]   noise_wave;
    logic [OUTPUT_BITS-1:0]   raw;
    logic                     pulse_hi;

    assign wsel[WSEL_SAWTOOTH] = en_sawtooth;
    assign wsel[WSEL_TRIANGLE] = en_triangle;
    assign wsel[WSEL_PULSE]    = en_pulse;
    assign wsel[WSEL_NOISE]    = en_noise;

    // Test and hard sync both clear the phase; sync beats a simultaneous wrap.
    always_comb begin
        acc_d = acc_q + {{(ACCUMULATOR_BITS - FREQ_BITS){1'b0}}, tone_freq};
        if (test || (en_sync && sync_source)) begin
            acc_d = '0;
        end
    end

    wave_lfsr #(
        .LFSR_BITS (LFSR_BITS),
        .OUT_BITS  (OUTPUT_BITS)
    ) u_lfsr (
        .main_clk  (main_clk),
        .reset     (reset),
        .reseed_i  (test),
        .advance_i (acc_q[NOISE_TAP_BIT] & ~prev_tap_q),
        .noise_o   (noise_wave)
    );

    assign saw_wave   = acc_q[MSB -: OUTPUT_BITS];
    assign tri_base   = acc_q[MSB-1 -: OUTPUT_BITS];
    assign tri_wave   = (acc_q[MSB] ^ (en_ringmod & ringmod_source)) ? ~tri_base : tri_base;
    assign pulse_hi   = test || (acc_q[MSB -: PULSEWIDTH_BITS] >= pulse_width);
    assign pulse_wave = {OUTPUT_BITS{pulse_hi}};

    always_comb begin
        raw = '1;
        if (wsel[WSEL_SAWTOOTH]) raw = raw & saw_wave;
        if (wsel[WSEL_TRIANGLE]) raw = raw & tri_wave;
        if (wsel[WSEL_PULSE])    raw = raw & pulse_wave;
        if (wsel[WSEL_NOISE])    raw = raw & noise_wave;
        if (wsel == '0)          raw = MIDSCALE;
    end

    always_ff @(posedge main_clk) begin
        if (reset) begin
            acc_q       <= '0;
            prev_msb_q  <= 1'b0;
            prev_tap_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            prev_msb_q  <= acc_q[MSB];
            prev_tap_q  <= acc_q[NOISE_TAP_BIT];
            out_valid_q <= sample_en;
            if (sample_en) begin
                out_q <= raw ^ MIDSCALE;
            end
        end
    end

    assign out              = out_q;
    assign out_valid        = out_valid_q;
    assign accumulator_msb  = acc_q[MSB];
    assign sync_trigger_out = acc_q[MSB] & ~prev_msb_q;

endmodule

// File: tb/tb_wave_voice.sv
// Self-checking bench for wave_voice: directed vector table, corner sequences and random stimulus vs a reference model.
`timescale 1ns/1ps
module tb_wave_voice;

    logic        main_clk = 1'b0;
    logic        reset, sample_en, test;
    logic        en_sawtooth, en_triangle, en_pulse, en_noise;
    logic        en_sync, sync_source, en_ringmod, ringmod_source;
    logic [15:0] tone_freq;
    logic [11:0] pulse_width;
    logic signed [11:0] out;
    logic        out_valid, accumulator_msb, sync_trigger_out;

    int total = 0;
    int bad   = 0;

    wave_voice dut (
        .main_clk         (main_clk),
        .reset            (reset),
        .tone_freq        (tone_freq),
        .pulse_width      (pulse_width),
        .sample_en        (sample_en),
        .test             (test),
        .en_sawtooth      (en_sawtooth),
        .en_triangle      (en_triangle),
        .en_pulse         (en_pulse),
        .en_noise         (en_noise),
        .en_sync          (en_sync),
        .sync_source      (sync_source),
        .en_ringmod       (en_ringmod),
        .ringmod_source   (ringmod_source),
        .out              (out),
        .out_valid        (out_valid),
        .accumulator_msb  (accumulator_msb),
        .sync_trigger_out (sync_trigger_out)
    );

    always #5 main_clk = ~main_clk;

    // Reference model: phase and noise register kept as plain integers.
    localparam longint unsigned ACC_MOD  = 64'd1 << 24;
    localparam longint unsigned LFSR_MOD = 64'd1 << 23;
    localparam longint unsigned SEED     = LFSR_MOD - 64'd8;

    longint unsigned m_acc, m_lfsr;
    bit m_prev_msb, m_prev_tap, m_vld;
    int m_out;

    function automatic bit bit_of(longint unsigned v, int b);
        return bit'((v >> b) & 64'd1);
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int raw, saw, tri_v, pul, noi;
        if (reset) begin
            m_acc = 0; m_prev_msb = 0; m_prev_tap = 0;
            m_lfsr = SEED; m_out = 0; m_vld = 0;
        end else begin
            if (sample_en) begin
                saw   = int'(m_acc / 4096);
                tri_v = int'((m_acc / 2048) % 4096);
                if (bit_of(m_acc, 23) != (en_ringmod && ringmod_source)) tri_v = 4095 - tri_v;
                pul   = (test || saw >= int'(pulse_width)) ? 4095 : 0;
                noi   = int'(m_lfsr / 2048);
                raw   = 4095;
                if (en_sawtooth) raw = raw & saw;
                if (en_triangle) raw = raw & tri_v;
                if (en_pulse)    raw = raw & pul;
                if (en_noise)    raw = raw & noi;
                if (!(en_sawtooth || en_triangle || en_pulse || en_noise)) raw = 2048;
                m_out = raw - 2048;
            end
            m_vld = sample_en;
            if (test)
                m_lfsr = SEED;
            else if (bit_of(m_acc, 19) && !m_prev_tap)
                m_lfsr = (m_lfsr * 2 + longint'(bit_of(m_lfsr, 22) ^ bit_of(m_lfsr, 17))) % LFSR_MOD;
            m_prev_msb = bit_of(m_acc, 23);
            m_prev_tap = bit_of(m_acc, 19);
            if (test || (en_sync && sync_source)) m_acc = 0;
            else m_acc = (m_acc + longint'(tone_freq)) % ACC_MOD;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge main_clk);
        #1;
        chk("out", int'(out), m_out);
        chk("out_valid", int'(out_valid), int'(m_vld));
        chk("acc_msb", int'(accumulator_msb), int'(bit_of(m_acc, 23)));
        chk("sync_trig", int'(sync_trigger_out), int'(bit_of(m_acc, 23) && !m_prev_msb));
    endtask

    task automatic do_reset();
        reset = 1'b1; sample_en = 1'b0; test = 1'b0; en_sync = 1'b0; sync_source = 1'b0;
        en_ringmod = 1'b0; ringmod_source = 1'b0;
        {en_noise, en_pulse, en_triangle, en_sawtooth} = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  en;   // {noise, pulse, triangle, sawtooth}
        logic        ring;
        logic [11:0] pw;
        logic [15:0] f;
        int          n;
        int          exp;
    } vec_t;

    vec_t vecs[12];

    task automatic run_vec(vec_t v);
        do_reset();
        {en_noise, en_pulse, en_triangle, en_sawtooth} = v.en;
        en_ringmod = v.ring; ringmod_source = v.ring;
        pulse_width = v.pw; tone_freq = v.f;
        repeat (v.n) tick();
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        chk("vec_out", int'(out), v.exp);
        chk("vec_valid", int'(out_valid), 1);
        tick();
        chk("vec_valid_drop", int'(out_valid), 0);
        chk("vec_hold", int'(out), v.exp);
    endtask

    int first_trig, n_trig, n_toggle, n_high;
    logic prev_msb_obs;

    initial begin
        vecs[0]  = '{4'b0001, 1'b0, 12'h000, 16'h1000, 2048,     0};
        vecs[1]  = '{4'b0001, 1'b0, 12'h000, 16'h1000,    1, -2047};
        vecs[2]  = '{4'b0010, 1'b0, 12'h000, 16'h1000, 1024,     0};
        vecs[3]  = '{4'b0010, 1'b0, 12'h000, 16'h1000, 3072,    -1};
        vecs[4]  = '{4'b0010, 1'b1, 12'h000, 16'h1000, 1024,    -1};
        vecs[5]  = '{4'b0010, 1'b1, 12'h000, 16'h1000, 3072,     0};
        vecs[6]  = '{4'b0100, 1'b0, 12'h800, 16'h1000, 1024, -2048};
        vecs[7]  = '{4'b0100, 1'b0, 12'h800, 16'h1000, 3072,  2047};
        vecs[8]  = '{4'b0100, 1'b0, 12'h000, 16'h1000,    7,  2047};
        vecs[9]  = '{4'b1000, 1'b0, 12'h000, 16'h1000,    1,  2047};
        vecs[10] = '{4'b0000, 1'b0, 12'h000, 16'h1000,  100,     0};
        vecs[11] = '{4'b0101, 1'b0, 12'h800, 16'h1000, 3072,  1024};

        tone_freq = 16'h0; pulse_width = 12'h0;
        do_reset();
        chk("reset_out", int'(out), 0);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_msb", int'(accumulator_msb), 0);
        chk("reset_trig", int'(sync_trigger_out), 0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Trigger cadence and MSB toggling.
        do_reset();
        tone_freq = 16'h1000;
        first_trig = -1; n_trig = 0; n_toggle = 0; prev_msb_obs = accumulator_msb;
        for (int i = 1; i <= 8192; i++) begin
            tick();
            if (sync_trigger_out) begin
                n_trig++;
                if (first_trig < 0) first_trig = i;
            end
            if (accumulator_msb != prev_msb_obs) n_toggle++;
            prev_msb_obs = accumulator_msb;
        end
        chk("trig_first", first_trig, 2048);
        chk("trig_count", n_trig, 2);
        chk("msb_toggles", n_toggle, 4);

        // Pulse duty at 50%.
        do_reset();
        en_pulse = 1'b1; pulse_width = 12'h800; tone_freq = 16'h1000; sample_en = 1'b1;
        n_high = 0;
        for (int i = 0; i < 4096; i++) begin
            tick();
            if (out == 12'sd2047) n_high++;
        end
        sample_en = 1'b0;
        chk("pulse_duty", n_high, 2048);

        // Test mode: pulse forced high, phase held at zero, resumes from zero.
        do_reset();
        en_pulse = 1'b1; pulse_width = 12'h800; tone_freq = 16'h1000; test = 1'b1;
        repeat (50) tick();
        sample_en = 1'b1;
        tick();
        chk("test_pulse", int'(out), 2047);
        en_pulse = 1'b0; en_sawtooth = 1'b1;
        tick();
        chk("test_acc_zero", int'(out), -2048);
        test = 1'b0;
        tick();
        tick();
        chk("test_resume", int'(out), -2047);
        sample_en = 1'b0;

        // Hard sync honoured, then ignored when disabled.
        do_reset();
        en_sawtooth = 1'b1; tone_freq = 16'h1000;
        repeat (12'h123) tick();
        en_sync = 1'b1; sync_source = 1'b1;
        tick();
        en_sync = 1'b0; sync_source = 1'b0; sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        chk("sync_clear", int'(out), -2048);
        do_reset();
        en_sawtooth = 1'b1; tone_freq = 16'h1000;
        repeat (12'h123) tick();
        sync_source = 1'b1;
        tick();
        sync_source = 1'b0; sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        chk("sync_ignored", int'(out), -1756);

        // Noise stepping, then reset mid-run with a simultaneous strobe.
        do_reset();
        en_noise = 1'b1; tone_freq = 16'h1000; sample_en = 1'b1;
        repeat (3000) tick();
        reset = 1'b1;
        tick();
        chk("midreset_out", int'(out), 0);
        chk("midreset_valid", int'(out_valid), 0);
        reset = 1'b0;
        tick();
        chk("midreset_seed", int'(out), 2047);
        sample_en = 1'b0;

        // Randomized operation against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i % 128 == 0) begin
                tone_freq = 16'($urandom);
                pulse_width = 12'($urandom);
                {en_noise, en_pulse, en_triangle, en_sawtooth} = 4'($urandom);
                en_ringmod = 1'($urandom);
                en_sync = 1'($urandom);
            end
            sample_en      = ($urandom_range(0, 3) == 0);
            sync_source    = ($urandom_range(0, 15) == 0);
            ringmod_source = 1'($urandom);
            test           = ($urandom_range(0, 99) == 0);
            reset          = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_voice.md
Name: wave_voice

Overview:
- Next-generation single-clock oscillator voice; replaces the fixed two-waveform generator.
- Phase accumulator drives sawtooth, triangle, pulse and noise waveforms; selected waveforms are AND-combined.
- Adds hard sync, ring modulation, a pulse-width comparator and a sample-strobed output register with a valid flag.
- Sits between the per-voice register file and the mixer; voices daisy-chain sync and ring-mod via accumulator_msb and sync_trigger_out.

Parameters:
- FREQ_BITS, 16, width of the tone_freq phase increment.
- PULSEWIDTH_BITS, 12, width of pulse_width; compared against the top PULSEWIDTH_BITS of the accumulator.
- OUTPUT_BITS, 12, output sample width. Must be <= LFSR_BITS and <= ACCUMULATOR_BITS-1.
- ACCUMULATOR_BITS, 24, phase accumulator width. Must be > FREQ_BITS.
- NOISE_TAP_BIT, 19, accumulator bit whose rising edge advances the LFSR.
- LFSR_BITS, 23, noise LFSR length.

Ports:
- main_clk, in, 1: sole clock.
- reset, in, 1: synchronous, active-high.
- tone_freq, in, FREQ_BITS: phase increment, zero-extended.
- pulse_width, in, PULSEWIDTH_BITS: pulse threshold.
- sample_en, in, 1: one-cycle sample strobe.
- test, in, 1: holds accumulator at 0, reseeds LFSR, forces pulse high.
- en_sawtooth / en_triangle / en_pulse / en_noise, in, 1 each: waveform selects.
- en_sync, in, 1: enable hard sync.
- sync_source, in, 1: one-cycle trigger from another voice's sync_trigger_out.
- en_ringmod, in, 1: enable ring modulation.
- ringmod_source, in, 1: another voice's accumulator_msb.
- out, out, OUTPUT_BITS signed: registered sample.
- out_valid, out, 1: high for one cycle when out updates.
- accumulator_msb, out, 1: acc[ACCUMULATOR_BITS-1].
- sync_trigger_out, out, 1: high for one cycle after acc MSB goes 0->1.

Behaviour:
- Reset (synchronous, highest priority): acc=0, prev_msb=0, prev_tap=0, LFSR=seed, out=0, out_valid=0. Therefore sync_trigger_out=0 and accumulator_msb=0.
- Accumulator priority per cycle: reset > test (acc<=0) > (en_sync && sync_source) (acc<=0) > acc<=acc+tone_freq.
  - Addition wraps modulo 2^ACCUMULATOR_BITS.
  - Sync and wrap in the same cycle: sync wins.
  - sync_source is ignored when en_sync=0.
- prev_msb <= acc MSB every cycle. sync_trigger_out = acc MSB & ~prev_msb.
  - Clearing the accumulator never produces a trigger.
- Noise LFSR:
  - Advances once per cycle in which acc[NOISE_TAP_BIT] & ~prev_tap.
  - Shift left; new LSB = bit[LFSR_BITS-1] ^ bit[LFSR_BITS-6].
  - Seed = all ones except the low 3 bits (23'h7FFFF8 at default).
  - test holds the LFSR at seed.
  - noise = top OUTPUT_BITS of the LFSR.
- Sawtooth: acc[ACCUMULATOR_BITS-1 -: OUTPUT_BITS].
- Triangle:
  - t = acc[ACCUMULATOR_BITS-2 -: OUTPUT_BITS].
  - m = acc MSB ^ (en_ringmod & ringmod_source).
  - triangle = m ? ~t : t.
- Pulse: all ones if acc[ACCUMULATOR_BITS-1 -: PULSEWIDTH_BITS] >= pulse_width, or if test=1; else all zeros.
  - pulse_width=0 gives constant high.
- Combine:
  - raw = all-ones ANDed with each enabled waveform.
  - No waveform enabled: raw = 2^(OUTPUT_BITS-1), i.e. silence (out=0).
- Output register:
  - On sample_en, out <= raw ^ 2^(OUTPUT_BITS-1), computed from the pre-update acc/LFSR of that cycle.
  - out_valid <= sample_en.
  - Latency 1 cycle. out holds between strobes.
  - sample_en during reset is ignored.
- test deasserted: accumulation resumes on the next cycle from 0.
- Reset mid-operation: all state clears on that edge; no partial sample is emitted.

Decomposition:
- Shared package wave_pkg:
  - LFSR seed constant and tap offsets.
  - Silence code helper: function midscale(OUTPUT_BITS).
  - Waveform-select bit-position constants, shared with the register file.
- One natural sub-module, wave_lfsr: LFSR with advance enable, test reseed and parametrised length.

Test Plan:
- Reset, then tone_freq=16'h1000, en_sawtooth=1, sample_en pulse at cycle 2048 after reset release -> acc=24'h800000, out=0 next cycle, out_valid=1 for exactly 1 cycle.
- Same increment, count cycles -> sync_trigger_out pulses once every 4096 cycles; first pulse at cycle 2048; accumulator_msb toggles every 2048 cycles.
- en_triangle only, sample at acc=24'h400000 -> out=0. At acc=24'hC00000 -> out=-1. Repeat with en_ringmod=1, ringmod_source=1 -> results swapped.
- en_pulse, pulse_width=12'h800 -> out alternates +2047 / -2048 with 50% duty. pulse_width=0 -> constant +2047. test=1 -> +2047 and acc stays 0.
- en_sync=1, sync_source pulse at acc=24'h123000 -> acc=0 next cycle. en_sync=0 with the same pulse -> acc continues (24'h124000).
- en_noise, tone_freq=16'h1000 -> LFSR advances every 256 cycles only. First sample equals the top 12 bits of seed (12'hFFF^12'h800 -> out=+2047). Reset asserted mid-run -> out=0, LFSR=seed next cycle. No waveforms enabled -> out=0.
